// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: the transmit FSM state encoding and the
//            oversampling constants used by the TX and RX bit timers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int TICK_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Counts 16x oversampling ticks and flags the last tick of each
//            bit time.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            tick_16x - single-cycle pulse at 16x the baud rate
//            enable   - count while high; counter held at 0 while low
//            bit_end  - single-cycle strobe on the tick that closes a bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tick_16x,
   input  logic enable,
   output logic bit_end
);

   localparam logic [TICK_CNT_W-1:0] c_LAST_TICK = TICK_CNT_W'(OVERSAMPLE - 1);

   logic [TICK_CNT_W-1:0] r_tick_cnt;

   // The counter wraps naturally from 15 back to 0 at each bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (!enable) begin
         r_tick_cnt <= '0;
      end else if (tick_16x) begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign bit_end = enable && tick_16x && (r_tick_cnt == c_LAST_TICK);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : UART transmitter. Accepts a word over valid/ready and shifts it
//            out as start, data (LSB first), optional parity and stop bits,
//            timed by the shared 16x oversampling tick.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            tick_16x - single-cycle pulse at 16x the baud rate
//            tx_data  - word to send, sampled at the handshake
//            tx_valid - tx_data is valid
//            tx_ready - a word can be accepted (IDLE only)
//            tx_out   - registered serial line, idles high
//            tx_busy  - a frame is in progress
//            tx_done  - one-cycle pulse after the final stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_16x,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam logic [2:0] c_LAST_IDX = 3'(DATA_BITS - 1);

   tx_state_e            r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_idx;
   logic                 r_parity;
   logic                 r_stop_cnt;
   logic                 r_out;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_bit_end;
   logic                 w_accept;
   logic                 w_parity_next;

   // r_busy is high in every state except IDLE, so it doubles as the timer
   // enable; the counter therefore sits at 0 while idle.
   uart_bit_timer u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .tick_16x (tick_16x),
      .enable   (r_busy),
      .bit_end  (w_bit_end)
   );

   assign w_accept      = tx_valid && r_ready;
   // Parity accumulates over the latched word as each bit leaves, so the
   // live input is never consulted after the handshake.
   assign w_parity_next = r_parity ^ r_shift[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_parity   <= 1'b0;
         r_stop_cnt <= 1'b0;
         r_out      <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shift    <= tx_data;
                  r_bit_idx  <= '0;
                  r_stop_cnt <= 1'b0;
                  // Seeding with 1 turns the running XOR into odd parity.
                  r_parity   <= (PARITY_ODD != 0);
                  r_out      <= 1'b0;
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_out   <= r_shift[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_parity <= w_parity_next;
                  if (r_bit_idx == c_LAST_IDX) begin
                     if (PARITY_EN != 0) begin
                        r_out   <= w_parity_next;
                        r_state <= PARITY;
                     end else begin
                        r_out   <= 1'b1;
                        r_state <= STOP;
                     end
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_out     <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  r_out   <= 1'b1;
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if ((STOP_BITS == 2) && !r_stop_cnt) begin
                     r_stop_cnt <= 1'b1;
                  end else begin
                     r_stop_cnt <= 1'b0;
                     r_ready    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= IDLE;
                  end
               end
            end
            default: begin
               r_out   <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign tx_out   = r_out;
   assign tx_ready = r_ready;
   assign tx_busy  = r_busy;
   assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_serializer
// Purpose  : Self-checking bench for uart_tx_serializer. Five differently
//            parameterised instances run side by side; each has a driver that
//            queues expected words and a monitor that rebuilds the frame from
//            the framing rules and compares the line tick by tick.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

   localparam int NCFG = 5;

   // cfg0 8N1, cfg1 8E1, cfg2 8O1, cfg3 8N2, cfg4 6O2
   function automatic int cfg_db(input int i);
      return (i == 4) ? 6 : 8;
   endfunction
   function automatic int cfg_pe(input int i);
      return (i == 1 || i == 2 || i == 4) ? 1 : 0;
   endfunction
   function automatic int cfg_po(input int i);
      return (i == 2 || i == 4) ? 1 : 0;
   endfunction
   function automatic int cfg_sb(input int i);
      return (i == 3 || i == 4) ? 2 : 1;
   endfunction
   function automatic logic [7:0] cfg_dir(input int i);
      case (i)
         0:       return 8'hA5;
         1, 2:    return 8'h07;
         3:       return 8'h81;
         default: return 8'h2D;
      endcase
   endfunction

   typedef struct {
      logic [7:0] data;
      bit         chained;   // valid was already waiting when the DUT was busy
   } exp_t;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic tick = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   phase = 0;
   bit   stop_mon = 1'b0;

   logic [NCFG-1:0] all_out, all_ready, all_busy, all_done;
   logic [NCFG-1:0] all_d1, all_d2, all_fin;

   always #5 clk = ~clk;

   // One tick every 4 clk cycles, changed 2 ns after the rising edge.
   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk);
         #2;
         c = (c + 1) % 4;
         tick = (c == 0);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired", name);
   endtask

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int DB = cfg_db(gi);
      localparam int PE = cfg_pe(gi);
      localparam int PO = cfg_po(gi);
      localparam int SB = cfg_sb(gi);

      logic [DB-1:0] data;
      logic          valid;
      logic          out, ready, busy, done;
      bit            d1, d2, fin;
      exp_t          q[$];

      uart_tx_serializer #(
         .DATA_BITS  (DB),
         .PARITY_EN  (PE),
         .PARITY_ODD (PO),
         .STOP_BITS  (SB)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .tick_16x (tick),
         .tx_data  (data),
         .tx_valid (valid),
         .tx_ready (ready),
         .tx_out   (out),
         .tx_busy  (busy),
         .tx_done  (done)
      );

      assign all_out[gi]   = out;
      assign all_ready[gi] = ready;
      assign all_busy[gi]  = busy;
      assign all_done[gi]  = done;
      assign all_d1[gi]    = d1;
      assign all_d2[gi]    = d2;
      assign all_fin[gi]   = fin;

      task automatic send(input logic [7:0] b, input bit hold);
         exp_t e;
         int   w;
         bit   chained;
         @(negedge clk);
         valid = 1'b1;
         data  = b[DB-1:0];
         chained = !ready;
         w = 0;
         while (!ready && w < 3000) begin
            @(negedge clk);
            w++;
         end
         if (!ready) begin
            fail_now($sformatf("cfg%0d_accept", gi));
            valid = 1'b0;
            return;
         end
         e.data = '0;
         e.data[DB-1:0] = b[DB-1:0];
         e.chained = chained;
         q.push_back(e);
         @(posedge clk);
         #1;
         if (!hold) valid = 1'b0;
         data = DB'($urandom());    // must not affect the frame in flight
      endtask

      task automatic wait_idle();
         int w;
         w = 0;
         while (!(ready && !busy) && w < 3000) begin
            @(negedge clk);
            w++;
         end
         if (!(ready && !busy)) fail_now($sformatf("cfg%0d_idle_wait", gi));
      endtask

      // Driver
      initial begin
         bit h;
         valid = 1'b0;
         data  = '0;
         d1 = 1'b0;
         d2 = 1'b0;
         wait (rst == 1'b0);
         repeat (3) @(negedge clk);
         send(cfg_dir(gi), 1'b0);
         send(8'h00, 1'b1);
         send(8'hFF, 1'b0);
         for (int k = 0; k < 8; k++) begin
            h = (k < 7) && ($urandom_range(0, 2) == 0);
            send(8'($urandom()), h);
            if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         wait_idle();
         d1 = 1'b1;
         wait (phase == 1);
         send(8'h42, 1'b0);     // data bit 3 is 0, so the reset release is visible
         wait (phase == 2);
         send(8'h3C, 1'b0);
         wait_idle();
         d2 = 1'b1;
      end

      // Monitor and reference model
      initial begin
         bit   in_frame, lost, tick_prev, pbit;
         int   n, nbits, cyc, last_done, line_err, idle_err, frames, ones;
         logic exp_bits[$];
         exp_t e;
         in_frame = 1'b0; lost = 1'b0; tick_prev = 1'b0;
         n = 0; nbits = 0; cyc = 0; last_done = -10;
         line_err = -1; idle_err = 0; frames = 0;
         fin = 1'b0;
         while (!stop_mon) begin
            @(negedge clk);
            cyc++;
            if (rst) begin
               in_frame = 1'b0;
               lost = 1'b0;
            end else if (in_frame) begin
               if (tick_prev) n++;
               if (n >= nbits * 16) begin
                  chk($sformatf("cfg%0d_line_first_bad_tick", gi), line_err, -1);
                  chk($sformatf("cfg%0d_end_{done,out,ready,busy}", gi),
                      int'({done, out, ready, busy}), 14);
                  in_frame = 1'b0;
                  last_done = cyc;
                  frames++;
               end else if (line_err < 0 &&
                            (out !== exp_bits[n / 16] || busy !== 1'b1 ||
                             ready !== 1'b0 || done !== 1'b0)) begin
                  line_err = n;
               end
            end else if (lost) begin
               if (out === 1'b1) lost = 1'b0;
            end else if (out === 1'b0) begin
               if (q.size() == 0) begin
                  fail_now($sformatf("cfg%0d_unexpected_start", gi));
                  lost = 1'b1;
               end else begin
                  e = q.pop_front();
                  chk($sformatf("cfg%0d_idle_errors", gi), idle_err, 0);
                  idle_err = 0;
                  exp_bits.delete();
                  exp_bits.push_back(1'b0);
                  ones = 0;
                  for (int k = 0; k < DB; k++) begin
                     exp_bits.push_back(e.data[k]);
                     ones += int'(e.data[k]);
                  end
                  if (PE != 0) begin
                     pbit = ((ones % 2) == 1) ^ (PO != 0);
                     exp_bits.push_back(pbit);
                  end
                  for (int s = 0; s < SB; s++) exp_bits.push_back(1'b1);
                  nbits = exp_bits.size();
                  n = 0;
                  line_err = -1;
                  if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) line_err = 0;
                  if (e.chained)
                     chk($sformatf("cfg%0d_gap_after_done", gi), cyc - last_done, 1);
                  in_frame = 1'b1;
               end
            end else if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
               idle_err++;
            end
            tick_prev = tick;
         end
         chk($sformatf("cfg%0d_idle_errors_final", gi), idle_err, 0);
         chk($sformatf("cfg%0d_leftover_expected", gi), q.size(), 0);
         chk($sformatf("cfg%0d_frames_completed", gi), frames, 12);
         fin = 1'b1;
      end
   end

   // Sequencer: reset checks, mid-frame reset, wrap-up.
   initial begin
      int  w;
      bit  ok;
      ok = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_out", int'(all_out), 31);
      chk("rst_ready", int'(all_ready), 31);
      chk("rst_busy", int'(all_busy), 0);
      chk("rst_done", int'(all_done), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_out", int'(all_out), 31);
      chk("post_rst_ready", int'(all_ready), 31);
      chk("post_rst_busy", int'(all_busy), 0);
      chk("post_rst_done", int'(all_done), 0);

      w = 0;
      while (all_d1 != 5'b11111 && w < 40000) begin
         @(negedge clk);
         w++;
      end
      if (all_d1 != 5'b11111) begin
         fail_now("phase0_complete");
         ok = 1'b0;
      end

      if (ok) begin
         phase = 1;
         w = 0;
         while (all_busy != 5'b11111 && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (all_busy != 5'b11111) begin
            fail_now("abort_frame_start");
            ok = 1'b0;
         end
      end

      if (ok) begin
         w = 0;
         while (w < 70) begin
            @(negedge clk);
            if (tick) w++;
         end
         @(negedge clk);
         chk("data_bit3_low", int'(all_out), 0);
         @(posedge clk);
         #2 rst = 1'b1;
         #1;
         chk("async_rst_out", int'(all_out), 31);
         chk("async_rst_busy", int'(all_busy), 0);
         chk("async_rst_done", int'(all_done), 0);
         repeat (3) @(negedge clk);
         @(posedge clk);
         #2 rst = 1'b0;
         phase = 2;
         w = 0;
         while (all_d2 != 5'b11111 && w < 5000) begin
            @(negedge clk);
            w++;
         end
         if (all_d2 != 5'b11111) fail_now("phase2_complete");
      end

      repeat (20) @(negedge clk);
      stop_mon = 1'b1;
      w = 0;
      while (all_fin != 5'b11111 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (all_fin != 5'b11111) fail_now("monitor_shutdown");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
